rom_loader_spi: RTL and testbench

//  Boot-time loader that copies the 32 KB ROM image from SPI flash into SRAM.

---
 rtl/rom_loader_spi.sv | 151 +++++++++++++++
 tb/tb_rom_loader_spi.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader_spi.sv
// Boot loader: one SPI READ (0x03) burst from flash, each byte written to SRAM via the romwrite_* port.
// Optional running byte checksum when ROMLOADER_CHECKSUM_EN is defined; otherwise checksum reads 16'h0000.
module rom_loader_spi #(
  parameter logic [23:0] FLASH_BASE = 24'h070000,
  parameter int unsigned LOAD_BYTES = 32768,
  parameter logic [18:0] SRAM_BASE  = 19'h40000,
  parameter int unsigned SCK_DIV    = 2,
  parameter int unsigned WR_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        flash_cs_n,
  output logic        flash_sck,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic [18:0] romwrite_addr,
  output logic [7:0]  romwrite_data,
  output logic        romwrite_wr,
  output logic        rom_initialised,
  output logic [15:0] checksum
);

  typedef enum logic [2:0] {
    S_START, S_CMD, S_RDBYTE, S_WRITE, S_GAP, S_DONE
  } state_t;

  localparam logic [31:0] CMD_WORD = {8'h03, FLASH_BASE};
  localparam logic [15:0] DIV_LAST = 16'(SCK_DIV - 1);
  localparam logic [15:0] WR_LAST  = 16'(WR_CYCLES - 1);
  localparam logic [15:0] IDX_LAST = 16'(LOAD_BYTES - 1);

  state_t      state;
  logic [15:0] div_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] index;
  logic [4:0]  bit_cnt;
  logic [31:0] shreg;
  logic [6:0]  rx;
  logic        div_last;
  logic        sck_rise;
  logic        sck_fall;
  logic        byte_done;

  assign div_last  = (div_cnt == DIV_LAST);
  assign sck_rise  = div_last && !flash_sck;
  assign sck_fall  = div_last && flash_sck;
  // Falling edge after the eighth data bit: wr rises here, data/addr were set at the last rise.
  assign byte_done = (state == S_RDBYTE) && sck_fall && (bit_cnt == 5'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_START;
      flash_cs_n      <= 1'b1;
      flash_sck       <= 1'b0;
      flash_mosi      <= 1'b0;
      romwrite_wr     <= 1'b0;
      romwrite_addr   <= SRAM_BASE;
      romwrite_data   <= 8'h00;
      rom_initialised <= 1'b0;
      div_cnt         <= '0;
      wr_cnt          <= '0;
      index           <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      rx              <= '0;
    end else begin
      case (state)
        S_START: begin
          flash_cs_n <= 1'b0;
          if (div_last) begin
            div_cnt    <= '0;
            flash_mosi <= CMD_WORD[31];
            shreg      <= {CMD_WORD[30:0], 1'b0};
            bit_cnt    <= '0;
            state      <= S_CMD;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        S_CMD, S_RDBYTE: begin
          div_cnt <= div_last ? 16'd0 : div_cnt + 16'd1;
          if (sck_rise) begin
            flash_sck <= 1'b1;
            if (state == S_RDBYTE) begin
              rx <= {rx[5:0], flash_miso};
              if (bit_cnt == 5'd7) begin
                romwrite_data <= {rx, flash_miso};
                romwrite_addr <= SRAM_BASE + {3'b000, index};
              end
            end
          end else if (sck_fall) begin
            // shreg is fully drained after the command, so mosi reads 0 during data bytes.
            flash_sck  <= 1'b0;
            bit_cnt    <= bit_cnt + 5'd1;
            flash_mosi <= shreg[31];
            shreg      <= {shreg[30:0], 1'b0};
            if (state == S_CMD && bit_cnt == 5'd31) begin
              bit_cnt    <= '0;
              flash_mosi <= 1'b0;
              state      <= S_RDBYTE;
            end else if (byte_done) begin
              bit_cnt     <= '0;
              romwrite_wr <= 1'b1;
              wr_cnt      <= '0;
              state       <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (wr_cnt == WR_LAST) begin
            wr_cnt      <= '0;
            romwrite_wr <= 1'b0;
            state       <= S_GAP;
          end else begin
            wr_cnt <= wr_cnt + 16'd1;
          end
        end
        S_GAP: begin
          div_cnt <= '0;
          if (index == IDX_LAST) begin
            flash_cs_n      <= 1'b1;
            rom_initialised <= 1'b1;
            state           <= S_DONE;
          end else begin
            index <= index + 16'd1;
            state <= S_RDBYTE;
          end
        end
        S_DONE: state <= S_DONE;
        default: state <= S_START;
      endcase
    end
  end

`ifdef ROMLOADER_CHECKSUM_EN
  logic [15:0] csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= 16'h0000;
    end else if (byte_done) begin
      csum <= csum + {8'h00, romwrite_data};
    end
  end

  assign checksum = csum;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_loader_spi.sv
// Directed bench for rom_loader_spi: three loaders with different geometry, SPI flash and SRAM-port monitors.
`timescale 1ns/1ps
module tb_rom_loader_spi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  cs_n, sck, mosi, miso, wr, init;
  logic [18:0] waddr [3];
  logic [7:0]  wdata [3];
  logic [15:0] csum  [3];

  int errors = 0;
  int checks = 0;
  int ecnt   = 0;

`ifdef ROMLOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  rom_loader_spi #(.LOAD_BYTES(4), .SCK_DIV(1), .WR_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .flash_cs_n(cs_n[0]), .flash_sck(sck[0]), .flash_mosi(mosi[0]),
    .flash_miso(miso[0]), .romwrite_addr(waddr[0]), .romwrite_data(wdata[0]),
    .romwrite_wr(wr[0]), .rom_initialised(init[0]), .checksum(csum[0]));

  rom_loader_spi #(.LOAD_BYTES(4), .SRAM_BASE(19'h7FFFE), .SCK_DIV(2), .WR_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .flash_cs_n(cs_n[1]), .flash_sck(sck[1]), .flash_mosi(mosi[1]),
    .flash_miso(miso[1]), .romwrite_addr(waddr[1]), .romwrite_data(wdata[1]),
    .romwrite_wr(wr[1]), .rom_initialised(init[1]), .checksum(csum[1]));

  rom_loader_spi #(.LOAD_BYTES(3), .SCK_DIV(1), .WR_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .flash_cs_n(cs_n[2]), .flash_sck(sck[2]), .flash_mosi(mosi[2]),
    .flash_miso(miso[2]), .romwrite_addr(waddr[2]), .romwrite_data(wdata[2]),
    .romwrite_wr(wr[2]), .rom_initialised(init[2]), .checksum(csum[2]));

  function automatic int wrc(input int g);
    return (g == 1) ? 3 : 2;
  endfunction

  // Flash image: loader 2 sees FF,FF,01; the others see byte[i] = i.
  function automatic logic fbit(input int g, input logic [23:0] a, input int n);
    logic [7:0] b;
    int k;
    int j;
    k = n / 8;
    j = n % 8;
    if (g == 2) b = (k < 2) ? 8'hFF : 8'h01;
    else        b = a[7:0] - 8'h00 + 8'(k);
    return b[7-j];
  endfunction

  function automatic logic [18:0] exp_addr(input int g, input int i);
    logic [18:0] t [4];
    if (g == 1) t = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
    else        t = '{19'h40000, 19'h40001, 19'h40002, 19'h40003};
    return t[i];
  endfunction

  function automatic logic [7:0] exp_data(input int g, input int i);
    logic [7:0] t [4];
    if (g == 2) t = '{8'hFF, 8'hFF, 8'h01, 8'h00};
    else        t = '{8'h00, 8'h01, 8'h02, 8'h03};
    return t[i];
  endfunction

  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  for (genvar g = 0; g < 3; g++) begin : mon
    int          bitcnt    = 0;
    int          nwr       = 0;
    int          hiw       = 0;
    int          viol      = 0;
    int          done_cyc  = 0;
    int          last_fall = 0;
    logic [31:0] cmdw      = '0;
    logic        sck_q     = 1'b0;
    logic        wr_q      = 1'b0;
    logic        init_q    = 1'b0;
    logic [18:0] addr_q    = '0;
    logic [18:0] hold_a    = '0;
    logic [7:0]  data_q    = '0;
    logic [7:0]  hold_d    = '0;
    logic [18:0] wa [8];
    logic [7:0]  wd [8];

    assign miso[g] = (bitcnt >= 32) ? fbit(g, cmdw[23:0], bitcnt - 32) : 1'b0;

    always @(negedge clk) begin
      sck_q  <= sck[g];
      wr_q   <= wr[g];
      init_q <= init[g];
      addr_q <= waddr[g];
      data_q <= wdata[g];
      if (rst || cs_n[g]) begin
        bitcnt <= 0;
      end else if (sck[g] && !sck_q) begin
        if (bitcnt < 32) cmdw <= {cmdw[30:0], mosi[g]};
        bitcnt <= bitcnt + 1;
      end
      if (wr[g] && init[g]) viol <= viol + 1;
      if (rst) begin
        nwr       <= 0;
        hiw       <= 0;
        done_cyc  <= 0;
        last_fall <= 0;
      end else begin
        if (wr[g] && !wr_q) begin
          if (nwr < 8) begin
            wa[nwr] <= waddr[g];
            wd[nwr] <= wdata[g];
          end
          nwr    <= nwr + 1;
          hiw    <= 1;
          hold_a <= waddr[g];
          hold_d <= wdata[g];
          if (waddr[g] != addr_q || wdata[g] != data_q) viol <= viol + 1;
        end else if (wr[g]) begin
          hiw <= hiw + 1;
          if (waddr[g] != hold_a || wdata[g] != hold_d) viol <= viol + 1;
        end else if (wr_q) begin
          if (hiw != wrc(g)) viol <= viol + 1;
          last_fall <= ecnt;
        end
        if (init[g] && !init_q) done_cyc <= ecnt;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (init !== 3'b111 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("load_done", {29'd0, init}, 32'h7);
    repeat (2) @(negedge clk);
    chk("idle_cs_n", {29'd0, cs_n}, 32'h7);
    chk("idle_sck", {29'd0, sck}, 32'h0);
    chk("idle_wr", {29'd0, wr}, 32'h0);
  endtask

`define CHECK_LOAD(G, N, T, CS) \
    chk($sformatf("cmd%0d", G), mon[G].cmdw, 32'h03070000); \
    chk($sformatf("nwr%0d", G), mon[G].nwr, N); \
    chk($sformatf("clks%0d", G), mon[G].done_cyc, T); \
    chk($sformatf("init_gap%0d", G), mon[G].done_cyc - mon[G].last_fall, 1); \
    chk($sformatf("wr_timing%0d", G), mon[G].viol, 0); \
    chk($sformatf("csum%0d", G), {16'd0, csum[G]}, CS_EN ? CS : 32'h0); \
    for (int i = 0; i < N; i++) begin \
      chk($sformatf("addr%0d_%0d", G, i), {13'd0, mon[G].wa[i]}, {13'd0, exp_addr(G, i)}); \
      chk($sformatf("data%0d_%0d", G, i), {24'd0, mon[G].wd[i]}, {24'd0, exp_data(G, i)}); \
    end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", {31'd0, cs_n[0]}, 32'h1);
    chk("rst_sck", {31'd0, sck[0]}, 32'h0);
    chk("rst_mosi", {31'd0, mosi[0]}, 32'h0);
    chk("rst_wr", {31'd0, wr[0]}, 32'h0);
    chk("rst_addr0", {13'd0, waddr[0]}, 32'h40000);
    chk("rst_addr1", {13'd0, waddr[1]}, 32'h7FFFE);
    chk("rst_data", {24'd0, wdata[0]}, 32'h0);
    chk("rst_init", {29'd0, init}, 32'h0);
    chk("rst_csum", {16'd0, csum[2]}, 32'h0);

    @(posedge clk); #1 rst = 1'b0;
    wait_done();
    // Clocks: SCK_DIV + 64*SCK_DIV + N*(16*SCK_DIV + WR_CYCLES + 1)
    `CHECK_LOAD(0, 4, 141, 32'h0006)
    `CHECK_LOAD(1, 4, 274, 32'h0006)
    `CHECK_LOAD(2, 3, 122, 32'h01FF)

    // Restart, then abort loader 0 while byte 2 is being written.
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (!(wr[0] === 1'b1 && waddr[0] === 19'h40002) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached", {31'd0, wr[0]}, 32'h1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", {31'd0, cs_n[0]}, 32'h1);
    chk("abort_wr", {31'd0, wr[0]}, 32'h0);
    chk("abort_sck", {31'd0, sck[0]}, 32'h0);
    chk("abort_addr", {13'd0, waddr[0]}, 32'h40000);
    chk("abort_data", {24'd0, wdata[0]}, 32'h0);
    chk("abort_csum", {16'd0, csum[0]}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    wait_done();
    `CHECK_LOAD(0, 4, 141, 32'h0006)
    `CHECK_LOAD(2, 3, 122, 32'h01FF)

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
